ws2812_frame_streamer: RTL and testbench

//  Upstream feeder for the WS2812 bit encoder. Holds a double-buffered GRB pixel store
//  (host writes the back bank, commit swaps banks at a frame boundary) and streams
//  NUM_LEDS pixels per frame over valid/ready. An internal timer starts each frame.
//  The encoder owns bit timing and the latch/reset gap; this block owns content and frame rate.

---
 rtl/ws2812_pkg.sv | 41 ++++
 rtl/ws2812_frame_streamer_if.sv | 39 +++
 rtl/ws2812_pixel_ram.sv | 72 +++++++
 rtl/ws2812_frame_streamer.sv | 149 ++++++++++++++
 tb/tb_ws2812_frame_streamer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ws2812_pkg.sv
// ============================================================================
//  Module   : ws2812_pkg
//  Brief    : Shared pixel width, GRB field slices and streamer FSM states.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package ws2812_pkg;

    localparam int PIX_W = 24;

    // GRB word layout; G goes out first on the wire.
    localparam int G_HI = 23;
    localparam int G_LO = 16;
    localparam int R_HI = 15;
    localparam int R_LO = 8;
    localparam int B_HI = 7;
    localparam int B_LO = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } state_t;

    function automatic logic [PIX_W-1:0] grb_pack(
        input logic [7:0] g,
        input logic [7:0] r,
        input logic [7:0] b
    );
        logic [PIX_W-1:0] pix;
        pix              = '0;
        pix[G_HI:G_LO]   = g;
        pix[R_HI:R_LO]   = r;
        pix[B_HI:B_LO]   = b;
        return pix;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ws2812_frame_streamer_if.sv
// ============================================================================
//  Module   : ws2812_frame_streamer_if
//  Brief    : Host write port and pixel stream bundle for the frame streamer.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface ws2812_frame_streamer_if #(
    parameter int AW = 3
);
    import ws2812_pkg::*;

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [PIX_W-1:0] wr_data;
    logic             commit;
    logic             commit_pending;
    logic [PIX_W-1:0] pix_data;
    logic             pix_valid;
    logic             pix_ready;
    logic             pix_last;
    logic             frame_busy;
    logic             overrun;

    // Host / encoder side.
    modport master (
        output wr_en, wr_addr, wr_data, commit, pix_ready,
        input  commit_pending, pix_data, pix_valid, pix_last, frame_busy, overrun
    );

    // Streamer side.
    modport slave (
        input  wr_en, wr_addr, wr_data, commit, pix_ready,
        output commit_pending, pix_data, pix_valid, pix_last, frame_busy, overrun
    );

endinterface

`default_nettype wire

// File: rtl/ws2812_pixel_ram.sv
// ============================================================================
//  Module   : ws2812_pixel_ram
//  Brief    : Two-bank pixel store, host write port plus 1-cycle sync read port.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ws2812_pixel_ram
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS = 8,
    parameter int AW       = 3
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             wr_en,
    input  wire logic             wr_bank,
    input  wire logic [AW-1:0]    wr_addr,
    input  wire logic [PIX_W-1:0] wr_data,
    input  wire logic             rd_en,
    input  wire logic             rd_bank,
    input  wire logic [AW-1:0]    rd_addr,
    output logic      [PIX_W-1:0] rd_data
);

    localparam int c_depth = 2 * NUM_LEDS;
    localparam int c_iw    = (c_depth > 1) ? $clog2(c_depth) : 1;

    logic [PIX_W-1:0] mem [0:c_depth-1];
    logic [c_iw-1:0]  w_wr_idx;
    logic [c_iw-1:0]  w_rd_idx;
    logic [PIX_W-1:0] rd_data_d;
    logic [PIX_W-1:0] rd_data_q;

    // Bank 1 sits directly above bank 0, so the store is exactly 2*NUM_LEDS deep.
    function automatic logic [c_iw-1:0] bank_index(
        input logic          bank,
        input logic [AW-1:0] a
    );
        return c_iw'(a) + (bank ? c_iw'(NUM_LEDS) : '0);
    endfunction

    assign w_wr_idx = bank_index(wr_bank, wr_addr);
    assign w_rd_idx = bank_index(rd_bank, rd_addr);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[w_wr_idx] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[w_rd_idx];
        end
    end

    // Read register holds its value between fetches, so it doubles as the pixel output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/ws2812_frame_streamer.sv
// ============================================================================
//  Module   : ws2812_frame_streamer
//  Brief    : Frame timer, double-buffered pixel store and valid/ready pixel feed.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ws2812_frame_streamer
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS = 8,
    parameter int AW       = 3,
    parameter int TICK_DIV = 833333
) (
    input  wire logic              clk,
    input  wire logic              rst,
    ws2812_frame_streamer_if.slave bus
);

    localparam int                c_tw        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int                c_aw1       = AW + 1;
    localparam logic [c_tw-1:0]   c_tick_max  = c_tw'(TICK_DIV - 1);
    localparam logic [c_aw1-1:0]  c_num_leds  = c_aw1'(NUM_LEDS);
    localparam logic [c_aw1-1:0]  c_last_addr = c_aw1'(NUM_LEDS - 1);

    logic [c_tw-1:0]  count_q, count_d;
    state_t           state_q, state_d;
    logic             front_sel_q, front_sel_d;
    logic             commit_pending_q, commit_pending_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             frame_busy_q, frame_busy_d;
    logic             pix_valid_q, pix_valid_d;
    logic             pix_last_q, pix_last_d;

    logic             w_tick;
    logic             w_start;
    logic             w_handshake;
    logic             w_wr_ok;
    logic             w_rd_en;
    logic [PIX_W-1:0] w_rd_data;

    assign w_tick      = (count_q == c_tick_max);
    assign w_start     = w_tick && (state_q == IDLE);
    assign w_handshake = pix_valid_q && bus.pix_ready;
    assign w_wr_ok     = bus.wr_en && ({1'b0, bus.wr_addr} < c_num_leds);
    assign w_rd_en     = (state_q == FETCH);

    always_comb begin
        count_d          = w_tick ? '0 : count_q + 1'b1;
        front_sel_d      = front_sel_q;
        commit_pending_d = commit_pending_q;

        // A commit arriving on the swap tick itself is latched for the next frame.
        if (w_start && commit_pending_q) begin
            front_sel_d      = ~front_sel_q;
            commit_pending_d = 1'b0;
        end else if (bus.commit) begin
            commit_pending_d = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        frame_busy_d = frame_busy_q;
        pix_valid_d  = pix_valid_q;
        pix_last_d   = pix_last_q;

        case (state_q)
            IDLE: begin
                if (w_tick) begin
                    addr_d       = '0;
                    frame_busy_d = 1'b1;
                    state_d      = FETCH;
                end
            end
            FETCH: begin
                pix_valid_d = 1'b1;
                pix_last_d  = ({1'b0, addr_q} == c_last_addr);
                state_d     = SEND;
            end
            SEND: begin
                if (w_handshake) begin
                    pix_valid_d = 1'b0;
                    pix_last_d  = 1'b0;
                    if (pix_last_q) begin
                        frame_busy_d = 1'b0;
                        state_d      = IDLE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q          <= '0;
            state_q          <= IDLE;
            front_sel_q      <= 1'b0;
            commit_pending_q <= 1'b0;
            addr_q           <= '0;
            frame_busy_q     <= 1'b0;
            pix_valid_q      <= 1'b0;
            pix_last_q       <= 1'b0;
        end else begin
            count_q          <= count_d;
            state_q          <= state_d;
            front_sel_q      <= front_sel_d;
            commit_pending_q <= commit_pending_d;
            addr_q           <= addr_d;
            frame_busy_q     <= frame_busy_d;
            pix_valid_q      <= pix_valid_d;
            pix_last_q       <= pix_last_d;
        end
    end

    // Host always writes the bank that is not being streamed.
    ws2812_pixel_ram #(
        .NUM_LEDS (NUM_LEDS),
        .AW       (AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_wr_ok),
        .wr_bank (~front_sel_q),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_en   (w_rd_en),
        .rd_bank (front_sel_q),
        .rd_addr (addr_q),
        .rd_data (w_rd_data)
    );

    assign bus.pix_data       = w_rd_data;
    assign bus.pix_valid      = pix_valid_q;
    assign bus.pix_last       = pix_last_q;
    assign bus.frame_busy     = frame_busy_q;
    assign bus.commit_pending = commit_pending_q;
    assign bus.overrun        = w_tick && (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ws2812_frame_streamer.sv
// ============================================================================
//  Module   : tb_ws2812_frame_streamer
//  Brief    : Directed bench for the frame streamer (4 LEDs, 64-cycle frame).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ws2812_frame_streamer;
    import ws2812_pkg::*;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   cyc_v;
    int   cyc_w;
    int   ov;
    int   n;
    int   target;
    logic stable;
    logic [23:0] p1, p2, p3, p4, pf;

    ws2812_frame_streamer_if #(.AW(3)) bus ();

    ws2812_frame_streamer #(
        .NUM_LEDS (4),
        .AW       (3),
        .TICK_DIV (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"},   {31'b0, bus.pix_valid},      32'd0);
        check({tag, "_data"},    {8'b0, bus.pix_data},        32'd0);
        check({tag, "_last"},    {31'b0, bus.pix_last},       32'd0);
        check({tag, "_busy"},    {31'b0, bus.frame_busy},     32'd0);
        check({tag, "_overrun"}, {31'b0, bus.overrun},        32'd0);
        check({tag, "_pending"}, {31'b0, bus.commit_pending}, 32'd0);
    endtask

    // Waits (bounded) for a valid pixel, captures it, then steps through its handshake.
    task automatic recv(output logic [23:0] d, output logic l);
        int k;
        k = 0;
        while (bus.pix_valid !== 1'b1 && k < 200) begin
            step();
            k++;
        end
        check("recv_valid", {31'b0, bus.pix_valid}, 32'd1);
        d = bus.pix_data;
        l = bus.pix_last;
        step();
    endtask

    task automatic check_frame(input string tag, input logic [23:0] e0, input logic [23:0] e1,
                               input logic [23:0] e2, input logic [23:0] e3);
        logic [23:0] e [4];
        logic [23:0] d;
        logic        l;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int i = 0; i < 4; i++) begin
            recv(d, l);
            check($sformatf("%s_data%0d", tag, i), {8'b0, d}, {8'b0, e[i]});
            check($sformatf("%s_last%0d", tag, i), {31'b0, l}, {31'b0, (i == 3)});
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [23:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        step();
        bus.wr_en   = 1'b0;
    endtask

    task automatic pulse_commit();
        bus.commit = 1'b1;
        step();
        bus.commit = 1'b0;
    endtask

    initial begin
        logic [23:0] d;
        logic        l;

        p1 = grb_pack(8'h11, 8'h22, 8'h33);
        p2 = grb_pack(8'h44, 8'h55, 8'h66);
        p3 = grb_pack(8'h77, 8'h88, 8'h99);
        p4 = grb_pack(8'hAA, 8'hBB, 8'hCC);
        pf = 24'hFFFFFF;

        rst           = 1'b0;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.commit    = 1'b0;
        bus.pix_ready = 1'b0;

        // Power-on reset and first-frame latency.
        repeat (5) step();
        check_zero("por");
        rst = 1'b1;
        repeat (64) step();
        check("lat_pre_valid", {31'b0, bus.pix_valid},  32'd0);
        check("lat_busy",      {31'b0, bus.frame_busy}, 32'd1);
        step();
        check("lat_valid",     {31'b0, bus.pix_valid},  32'd1);
        bus.pix_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            recv(d, l);
            check($sformatf("por_last%0d", i), {31'b0, l}, {31'b0, (i == 3)});
        end
        check("por_busy_end", {31'b0, bus.frame_busy}, 32'd0);

        // Fill back bank and commit.
        wr(3'd0, p1);
        wr(3'd1, p2);
        wr(3'd2, p3);
        wr(3'd3, p4);
        pulse_commit();
        check("commit_pending_set", {31'b0, bus.commit_pending}, 32'd1);

        recv(d, l);
        check("commit_pending_clr", {31'b0, bus.commit_pending}, 32'd0);
        check("f1_data0", {8'b0, d}, {8'b0, p1});
        check("f1_last0", {31'b0, l}, 32'd0);

        // Stall on pixel 1 while overwriting the back bank.
        bus.pix_ready = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i < 4) begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = 3'(i);
                bus.wr_data = pf;
            end else begin
                bus.wr_en = 1'b0;
            end
            step();
            if (bus.pix_valid !== 1'b1 || bus.pix_data !== p2) stable = 1'b0;
        end
        bus.wr_en = 1'b0;
        check("stall_stable", {31'b0, stable}, 32'd1);
        bus.pix_ready = 1'b1;
        recv(d, l);
        check("f1_data1", {8'b0, d}, {8'b0, p2});
        recv(d, l);
        check("f1_data2", {8'b0, d}, {8'b0, p3});
        recv(d, l);
        check("f1_data3", {8'b0, d}, {8'b0, p4});
        check("f1_last3", {31'b0, l}, 32'd1);
        check("f1_busy_end", {31'b0, bus.frame_busy}, 32'd0);

        // Replay without commit, then commit the 0xFFFFFF bank.
        check_frame("replay_a", p1, p2, p3, p4);
        check_frame("replay_b", p1, p2, p3, p4);
        pulse_commit();
        check("commit2_pending", {31'b0, bus.commit_pending}, 32'd1);
        check_frame("white", pf, pf, pf, pf);

        // Long stall across two ticks.
        bus.pix_ready = 1'b0;
        n = 0;
        while (bus.pix_valid !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check("ovr_wait_valid", {31'b0, bus.pix_valid}, 32'd1);
        cyc_v = cyc;
        ov = 0;
        for (int i = 0; i < 150; i++) begin
            if (bus.overrun === 1'b1) ov++;
            step();
        end
        check("ovr_count", ov,                          32'd2);
        check("ovr_busy",  {31'b0, bus.frame_busy},     32'd1);
        check("ovr_valid", {31'b0, bus.pix_valid},      32'd1);
        check("ovr_data",  {8'b0, bus.pix_data},        {8'b0, pf});
        bus.pix_ready = 1'b1;
        check_frame("ovr_frame", pf, pf, pf, pf);
        check("ovr_busy_end", {31'b0, bus.frame_busy}, 32'd0);
        n = 0;
        while (bus.pix_valid !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check("ovr_next_start", cyc, cyc_v + 192);
        cyc_w = cyc;
        check_frame("ovr_next", pf, pf, pf, pf);

        // Out-of-range write, and commit landing on the tick cycle.
        wr(3'd5, 24'h123456);
        target = cyc_w - 2 + 64;
        n = 0;
        while (cyc < target && n < 200) begin
            step();
            n++;
        end
        check("tick_align", cyc, target);
        pulse_commit();
        check("tick_commit_pending", {31'b0, bus.commit_pending}, 32'd1);
        check_frame("deferred", pf, pf, pf, pf);
        check_frame("swapped", p1, p2, p3, p4);
        check("swapped_pending", {31'b0, bus.commit_pending}, 32'd0);
        wr(3'd5, 24'h123456);
        check_frame("oob_guard", p1, p2, p3, p4);

        // Reset in the middle of a frame.
        n = 0;
        while (bus.pix_valid !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check("mid_wait_valid", {31'b0, bus.pix_valid}, 32'd1);
        rst = 1'b0;
        #1;
        check_zero("mid_rst");
        repeat (5) step();
        rst = 1'b1;
        repeat (64) step();
        check("mid_lat_pre", {31'b0, bus.pix_valid}, 32'd0);
        step();
        check("mid_lat_valid", {31'b0, bus.pix_valid}, 32'd1);
        check_frame("mid_bank0", pf, pf, pf, pf);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
